// File: rtl/prochot_ctrl.sv
// Multi-socket PROCHOT# generator: synchronised, glitch-filtered causes gated by
// enables and qualification, with a guaranteed minimum assertion width and sticky flags.
module prochot_ctrl #(
  parameter int NUM_SKT        = 2,
  parameter int FILT_CYC       = 4,
  parameter int MIN_ASSERT_CYC = 2000
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iPwrOk,
  input  logic [NUM_SKT-1:0] iSktOcc_n,
  input  logic [NUM_SKT-1:0] iVrHot_n,
  input  logic [NUM_SKT-1:0] iPwrInAlert_n,
  input  logic               iSysThrottle,
  input  logic [2:0]         iSrcEn,
  input  logic               iStsClr,
  output logic [NUM_SKT-1:0] oProchot_n,
  output logic [NUM_SKT-1:0] oStsVrHot,
  output logic [NUM_SKT-1:0] oStsPwrAlert,
  output logic               oStsThrottle
);

  localparam int NIN = 2*NUM_SKT + 1;
  localparam int FW  = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam int CW  = $clog2(MIN_ASSERT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYC - 1);
  localparam logic [CW-1:0] MIN_CNT   = CW'(MIN_ASSERT_CYC);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

  // All causes normalised to active-high so that reset value 0 means deasserted.
  logic [NIN-1:0] raw_asrt;
  logic [NIN-1:0] sync_p0, sync_p1, filt_p2;
  logic [FW-1:0]  filt_cnt_p2 [NIN];

  assign raw_asrt = {iSysThrottle, ~iPwrInAlert_n, ~iVrHot_n};

  // Stage p0/p1: two-flop synchroniser
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_asrt;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce, flip only after FILT_CYC consecutive disagreeing cycles
  always_ff @(posedge iClk) begin
    for (int i = 0; i < NIN; i++) begin
      if (!iRst_n) begin
        filt_p2[i]     <= 1'b0;
        filt_cnt_p2[i] <= '0;
      end else if (sync_p1[i] == filt_p2[i]) begin
        filt_cnt_p2[i] <= '0;
      end else if (filt_cnt_p2[i] == FILT_LAST) begin
        filt_p2[i]     <= sync_p1[i];
        filt_cnt_p2[i] <= '0;
      end else begin
        filt_cnt_p2[i] <= filt_cnt_p2[i] + FW'(1);
      end
    end
  end

  logic [NUM_SKT-1:0] vrhot_f, alert_f;
  logic               throttle_f;
  logic [NUM_SKT-1:0] cause, qual;

  assign vrhot_f    = filt_p2[NUM_SKT-1:0];
  assign alert_f    = filt_p2[2*NUM_SKT-1:NUM_SKT];
  assign throttle_f = filt_p2[NIN-1];

  assign cause = ({NUM_SKT{iSrcEn[0]}} & vrhot_f)
               | ({NUM_SKT{iSrcEn[1]}} & alert_f)
               | {NUM_SKT{iSrcEn[2] & throttle_f}};
  assign qual  = {NUM_SKT{iPwrOk}} & ~iSktOcc_n;

  state_t             state_p3     [NUM_SKT];
  state_t             state_nxt    [NUM_SKT];
  logic [CW-1:0]      cnt_p3       [NUM_SKT];
  logic [CW-1:0]      cnt_nxt      [NUM_SKT];
  logic [NUM_SKT-1:0] prochot_n_p3, prochot_n_nxt;

  // Stage p3: per-socket minimum-width FSM
  always_ff @(posedge iClk) begin
    for (int s = 0; s < NUM_SKT; s++) begin
      if (!iRst_n) begin
        state_p3[s]     <= IDLE;
        cnt_p3[s]       <= '0;
        prochot_n_p3[s] <= 1'b1;
      end else begin
        state_p3[s]     <= state_nxt[s];
        cnt_p3[s]       <= cnt_nxt[s];
        prochot_n_p3[s] <= prochot_n_nxt[s];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SKT; s++) begin
      state_nxt[s] = state_p3[s];
      if (!qual[s]) begin
        state_nxt[s] = IDLE;
      end else begin
        case (state_p3[s])
          IDLE:    if (cause[s]) state_nxt[s] = ASSERT;
          ASSERT:  if (!cause[s]) state_nxt[s] = (cnt_p3[s] >= MIN_CNT) ? IDLE : HOLD;
          HOLD: begin
            if (cause[s])                  state_nxt[s] = ASSERT;
            else if (cnt_p3[s] >= MIN_CNT) state_nxt[s] = IDLE;
          end
          default: state_nxt[s] = IDLE;
        endcase
      end
    end
  end

  // Counter holds the number of low cycles including the one being entered.
  always_comb begin
    for (int s = 0; s < NUM_SKT; s++) begin
      cnt_nxt[s]       = cnt_p3[s];
      prochot_n_nxt[s] = (state_nxt[s] == IDLE);
      if (state_nxt[s] == IDLE)
        cnt_nxt[s] = '0;
      else if (state_p3[s] == IDLE)
        cnt_nxt[s] = CW'(1);
      else if (cnt_p3[s] < MIN_CNT)
        cnt_nxt[s] = cnt_p3[s] + CW'(1);
    end
  end

  logic [NUM_SKT-1:0] sts_vr_p3, sts_pa_p3;
  logic               sts_thr_p3;
  logic [NUM_SKT-1:0] set_vr, set_pa;
  logic               set_thr;

  assign set_vr  = vrhot_f & {NUM_SKT{iSrcEn[0]}} & qual;
  assign set_pa  = alert_f & {NUM_SKT{iSrcEn[1]}} & qual;
  assign set_thr = throttle_f & iSrcEn[2] & (|qual);

  // Sticky flags: set has priority over a coincident clear
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sts_vr_p3  <= '0;
      sts_pa_p3  <= '0;
      sts_thr_p3 <= 1'b0;
    end else begin
      sts_vr_p3  <= set_vr | (sts_vr_p3 & {NUM_SKT{~iStsClr}});
      sts_pa_p3  <= set_pa | (sts_pa_p3 & {NUM_SKT{~iStsClr}});
      sts_thr_p3 <= set_thr | (sts_thr_p3 & ~iStsClr);
    end
  end

  assign oProchot_n   = prochot_n_p3;
  assign oStsVrHot    = sts_vr_p3;
  assign oStsPwrAlert = sts_pa_p3;
  assign oStsThrottle = sts_thr_p3;

endmodule

// File: doc/prochot_ctrl.md
# prochot_ctrl

Multi-socket PROCHOT# generator; parametrised successor to the single-socket combinational PROCHOT# gate in the core CPLD. Per socket it synchronises and glitch-filters the VRHOT#, PSU power-in alert and global system-throttle causes, gates them with per-cause enables, power-good and socket presence, and drives PROCHOT# with a guaranteed minimum assertion width. Sticky cause flags latch for BMC readout over the existing register interface.

## Interface
Parameters:
- NUM_SKT, 2: number of CPU sockets (1..8).
- FILT_CYC, 4: consecutive stable cycles required before a synchronised cause changes its filtered value (>=1).
- MIN_ASSERT_CYC, 2000: minimum PROCHOT# low time in iClk cycles (1 ms at 2 MHz; >=1).

Ports:
- iClk  in  1  2 MHz system clock.
- iRst_n  in  1  reset, synchronous, active-low; clock iClk.
- iPwrOk  in  1  PWRGD_SYS_PWROK; synchronous board-level qualifier, used unsynchronised.
- iSktOcc_n  in  NUM_SKT  socket-occupied, active-low; static, used unsynchronised.
- iVrHot_n  in  NUM_SKT  per-socket VCCIN VRHOT#, asynchronous.
- iPwrInAlert_n  in  NUM_SKT  per-socket power-in alert, asynchronous.
- iSysThrottle  in  1  ME throttle request, active-high, asynchronous, applies to all sockets.
- iSrcEn  in  3  cause enables: bit0 VRHOT, bit1 power alert, bit2 throttle.
- iStsClr  in  1  one-cycle pulse, clears all sticky flags.
- oProchot_n  out  NUM_SKT  per-socket PROCHOT#, active-low, registered.
- oStsVrHot  out  NUM_SKT  sticky: VRHOT caused assertion.
- oStsPwrAlert  out  NUM_SKT  sticky: power alert caused assertion.
- oStsThrottle  out  1  sticky: system throttle caused assertion.

## Operation
- Each asynchronous input (2*NUM_SKT+1 bits) passes a 2-FF synchroniser, then a debounce counter: filtered value flips only after the synchronised value differs from it for FILT_CYC consecutive cycles; any agreeing cycle resets the counter. Filter reset value = deasserted.
- Cause[s] = (iSrcEn[0] & vrhot_f[s]) | (iSrcEn[1] & alert_f[s]) | (iSrcEn[2] & throttle_f).
- Qual[s] = iPwrOk & !iSktOcc_n[s].
- Per-socket FSM, counter width $clog2(MIN_ASSERT_CYC+1), saturating at MIN_ASSERT_CYC:
  - IDLE: oProchot_n=1, counter=0. Qual & Cause -> ASSERT.
  - ASSERT: oProchot_n=0, counter increments. !Cause & counter>=MIN_ASSERT_CYC -> IDLE; !Cause & counter<MIN_ASSERT_CYC -> HOLD.
  - HOLD: oProchot_n=0, counter increments. Cause -> ASSERT (counter not reset); counter>=MIN_ASSERT_CYC -> IDLE.
  - !Qual in any state -> IDLE next cycle, counter cleared; overrides minimum width.
- Sticky flags: each set in any cycle where its enabled filtered cause is active and Qual[s] (oStsThrottle: any socket qualified). iStsClr clears all; set wins over simultaneous clear.
- Changing iSrcEn takes effect on the next cycle as a cause change; no filter delay.

## Timing
- Reset: oProchot_n all 1, all sticky 0, FSMs IDLE, synchronisers/filters deasserted, counters 0.
- Cause assert latency: raw edge sampled at edge 0 -> oProchot_n low after 3+FILT_CYC edges (2 sync, FILT_CYC filter, 1 FSM register).
- Deassert: same pipeline, then held low until total low time >= MIN_ASSERT_CYC cycles.
- Glitch of fewer than FILT_CYC synchronised cycles never reaches oProchot_n or stickies.
- Sticky sets same cycle as FSM leaves IDLE; visible one cycle later.
- Sockets fully independent; throttle drives all qualified sockets on the same cycle.

## Test plan
(FILT_CYC=4, MIN_ASSERT_CYC=8, NUM_SKT=2, iSrcEn=3'b111, iPwrOk=1, both occupied.)
- iVrHot_n[0] low for 20 cycles -> oProchot_n[0] low 7 cycles after first sample, rises 7 cycles after release; oProchot_n[1] stays 1; oStsVrHot=2'b01.
- iPwrInAlert_n[1] low 3 cycles -> no change on oProchot_n, oStsPwrAlert=0; low 5 cycles -> oProchot_n[1] low exactly 8 cycles.
- iSysThrottle high 10 cycles -> both outputs low same cycle; oStsThrottle=1; iStsClr coincident with continued cause -> flag stays 1.
- iPwrOk drops while oProchot_n[0] low for 2 cycles -> oProchot_n[0]=1 next cycle; iSktOcc_n[1]=1 blocks throttle on socket 1.
- iSrcEn=3'b110 with iVrHot_n[0] low -> oProchot_n[0]=1, oStsVrHot=0; set bit0 -> low next cycle.
- iRst_n low mid-assertion -> next cycle all outputs 1, stickies 0; re-assertion needs full 3+FILT_CYC latency.
